// File: rtl/sha256_pkg.sv
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared constants, FSM encoding and SHA-256 helper functions
//                for the PCPI SHA-256 compression engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    // Custom-0 instruction encoding and funct7 sub-operations
    localparam logic [6:0] SHA_OPCODE = 7'b0001011;
    localparam logic [2:0] SHA_FUNCT3 = 3'b000;
    localparam logic [6:0] F7_INIT    = 7'h00;
    localparam logic [6:0] F7_LOAD    = 7'h01;
    localparam logic [6:0] F7_RUN     = 7'h02;
    localparam logic [6:0] F7_READ    = 7'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// ============================================================================
//  Module      : sha256_round
//  Description : Combinational single SHA-256 round. vars[0..7] = a..h.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] vars_in,
    input  logic [31:0]      k,
    input  logic [31:0]      w,
    output logic [7:0][31:0] vars_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    // One compression round: new a/e from T1/T2, everything else shifts down
    always_comb begin
        t1 = vars_in[7] + big_sigma1(vars_in[4]) + ch(vars_in[4], vars_in[5], vars_in[6]) + k + w;
        t2 = big_sigma0(vars_in[0]) + maj(vars_in[0], vars_in[1], vars_in[2]);
        vars_out[0] = t1 + t2;
        vars_out[1] = vars_in[0];
        vars_out[2] = vars_in[1];
        vars_out[3] = vars_in[2];
        vars_out[4] = vars_in[3] + t1;
        vars_out[5] = vars_in[4];
        vars_out[6] = vars_in[5];
        vars_out[7] = vars_in[6];
    end

endmodule

`default_nettype wire

// File: rtl/pcpi_sha256_engine.sv
// ============================================================================
//  Module      : pcpi_sha256_engine
//  Description : Multi-cycle SHA-256 compression coprocessor on the picorv32
//                PCPI port (INIT / LOAD / RUN / READ custom-0 instructions).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcpi_sha256_engine
    import sha256_pkg::*;
#(
    parameter logic [6:0] OPCODE = SHA_OPCODE,
    parameter logic [2:0] FUNCT3 = SHA_FUNCT3
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        busy
);

    state_t           state;
    state_t           state_next;
    logic [31:0]      h_reg [0:7];
    logic [31:0]      w_reg [0:15];
    logic [7:0][31:0] wv;
    logic [7:0][31:0] wv_next;
    logic [5:0]       round_cnt;
    logic             guard;
    logic [31:0]      rd_q;
    logic             wr_q;
    logic [6:0]       funct7;
    logic             match;
    logic             fire;
    logic             unused_bits;

    assign funct7      = pcpi_insn[31:25];
    assign match       = (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[14:12] == FUNCT3)
                         && (funct7[6:2] == 5'd0);
    // guard blocks the still-held valid in the cycle right after a ready pulse
    assign fire        = (state == ST_IDLE) && pcpi_valid && match && !guard;
    assign pcpi_wait   = match && pcpi_valid && (state != ST_ACK) && (state != ST_DONE);
    assign pcpi_ready  = (state == ST_ACK) || (state == ST_DONE);
    assign pcpi_rd     = rd_q;
    assign pcpi_wr     = wr_q;
    assign busy        = (state == ST_ROUND) || (state == ST_FINAL);
    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs2[31:4]};

    sha256_round u_round (
        .vars_in  (wv),
        .k        (K[round_cnt]),
        .w        (w_reg[0]),
        .vars_out (wv_next)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fire) state_next = (funct7 == F7_RUN) ? ST_ROUND : ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            ST_ROUND: if (round_cnt == 6'd63) state_next = ST_FINAL;
            ST_FINAL: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: chaining state, message schedule, working vars and result regs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++)  h_reg[i] <= IV[i];
            for (int i = 0; i < 16; i++) w_reg[i] <= 32'd0;
            wv        <= '0;
            round_cnt <= 6'd0;
            guard     <= 1'b0;
            rd_q      <= 32'd0;
            wr_q      <= 1'b0;
        end else begin
            guard <= pcpi_ready;
            rd_q  <= 32'd0;
            wr_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        case (funct7)
                            F7_INIT: for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
                            F7_LOAD: w_reg[pcpi_rs2[3:0]] <= pcpi_rs1;
                            F7_RUN: begin
                                for (int i = 0; i < 8; i++) wv[i] <= h_reg[i];
                                round_cnt <= 6'd0;
                            end
                            default: begin
                                rd_q <= h_reg[pcpi_rs1[2:0]];
                                wr_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ROUND: begin
                    wv        <= wv_next;
                    round_cnt <= round_cnt + 6'd1;
                    for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i + 1];
                    w_reg[15] <= small_sigma1(w_reg[14]) + w_reg[9]
                               + small_sigma0(w_reg[1]) + w_reg[0];
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/pcpi_sha256_engine.md
Name: pcpi_sha256_engine

Overview:
- Multi-cycle SHA-256 compression coprocessor on the picorv32 PCPI port; consumes the custom instructions the core forwards and returns results through pcpi_rd.
- Software loads a 16-word block, runs the compression, and reads back the 8-word chaining state.
- Holds the chaining state internally, so multi-block messages need no software intervention between blocks beyond reloading W.

Parameters:
- OPCODE, 7'b0001011, custom-0 major opcode decoded from pcpi_insn[6:0].
- FUNCT3, 3'b000, required pcpi_insn[14:12].

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  core presents an unrecognised instruction; held until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  rs1 value
- pcpi_rs2  in  32  rs2 value
- pcpi_wr  out  1  rd write enable, valid with pcpi_ready
- pcpi_rd  out  32  result, valid with pcpi_ready
- pcpi_wait  out  1  stall request while a recognised instruction is executing
- pcpi_ready  out  1  single-cycle completion pulse
- busy  out  1  high during ROUND/FINAL (debug/perf)

Behaviour:
- Decode match requires opcode==OPCODE, funct3==FUNCT3, and funct7 (insn[31:25]) in 0x00..0x03. Mismatch: no wait, no ready; the core times out and traps.
- funct7 0x00 SHA_INIT: H[0..7] <= FIPS IV (6a09e667..5be0cd19). pcpi_wr=0.
- funct7 0x01 SHA_LOAD: W[rs2[3:0]] <= rs1. pcpi_wr=0.
- funct7 0x02 SHA_RUN: 64 rounds on W, then H[i] += working var i (mod 2^32). pcpi_wr=0.
- funct7 0x03 SHA_READ: pcpi_rd = H[rs1[2:0]], pcpi_wr=1. Upper rs1 bits are ignored.
- FSM states: IDLE, ACK, ROUND, FINAL, DONE.
  - IDLE + matched valid: INIT, LOAD, and READ perform their action and go to ACK. RUN loads a..h from H, clears the round counter, and goes to ROUND.
  - ACK: pcpi_ready=1 for one cycle, then go to IDLE.
  - ROUND: one round per cycle for t=0..63 using K[t] and W[0]. W shifts down by one; W[15] <= σ1(W[14]) + W[9] + σ0(W[1]) + W[0]. At t==63 go to FINAL.
  - FINAL: update H, then go to DONE.
  - DONE: pcpi_ready=1 for one cycle, then go to IDLE.
- pcpi_wait = matched decode && pcpi_valid && state!=ACK/DONE; it is combinational from decode.
- Latency, counted from the cycle pcpi_valid is first sampled (cycle 0):
  - INIT/LOAD/READ: pcpi_ready in cycle 1.
  - RUN: ROUND occupies cycles 1..64, FINAL is cycle 65, pcpi_ready in cycle 66.
- Re-issue guard: pcpi_valid is ignored in the cycle immediately after pcpi_ready, because the core still holds valid there.
- pcpi_rd and pcpi_wr are registered and driven only while pcpi_ready=1; otherwise they are 0.
- W is consumed by RUN (contents after RUN are the expanded schedule). Software must reload all 16 words before each block.
- Reset (async assert, sync-deassert handled upstream): state=IDLE, H=IV, W=0, counter=0, all outputs 0. Reset mid-RUN aborts cleanly with no partial H update.
- All arithmetic is 32-bit modulo 2^32. Rotations follow FIPS 180-4 (Σ0: 2,13,22; Σ1: 6,11,25; σ0: 7,18,>>3; σ1: 17,19,>>10).

Decomposition:
- Package sha256_pkg holds:
  - opcode/funct constants, FSM state encoding;
  - IV array and K[0..63] constant table;
  - Σ/σ/Ch/Maj functions.
- Sub-module sha256_round: combinational single-round step, a..h, K, W in → a'..h' out. It is instantiated once in the engine.

Test Plan:
- INIT, LOAD "abc" padded block (61626380, 0×14, 00000018), RUN, READ×8 → ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- INIT, LOAD empty-message block (80000000, 0×15), RUN, READ → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefg…nopq" (448 bits): INIT, LOAD/RUN block 1, LOAD/RUN block 2 → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Latency/handshake:
  - RUN: pcpi_wait high for cycles 0..65, pcpi_ready exactly one pulse at cycle 66, no second ready despite valid held in cycle 67.
  - READ: ready at cycle 1 with pcpi_wr=1.
- Unknown funct7 0x05 or funct3 001 with valid held 20 cycles → pcpi_wait=0 and pcpi_ready=0 throughout; the H state is unchanged.
- Assert resetn=0 at round 30 of RUN, release, then READ H[0] → 6a09e667, and state returns to IDLE.
